// File: rtl/traffic_ctrl_nway.sv
// N-way traffic-light controller: each handover runs GREEN -> YELLOW -> ALL_RED.
// Green holds for a minimum and extends on its own request, capped when others wait.
module traffic_ctrl_nway #(
  parameter int NUM_WAYS     = 4,
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN    = 2,
  parameter int MAX_GREEN    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_WAYS-1:0]         req,
  input  logic                        prio_mode,
  output logic [NUM_WAYS-1:0]         green,
  output logic [NUM_WAYS-1:0]         yellow,
  output logic [$clog2(NUM_WAYS)-1:0] active_way,
  output logic [1:0]                  phase,
  output logic [CNT_W-1:0]            counter_out
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  if (NUM_WAYS < 2) begin : gBadWays
    $error("NUM_WAYS must be at least 2");
  end
  if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || MAX_GREEN >= (64'd1 << CNT_W)) begin : gBadGreen
    $error("Need 1 <= MIN_GREEN <= MAX_GREEN < 2**CNT_W");
  end
  if (YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
      YELLOW_TIME > (64'd1 << CNT_W) || ALL_RED_TIME > (64'd1 << CNT_W)) begin : gBadTimes
    $error("YELLOW_TIME and ALL_RED_TIME must be >= 1 and fit the counter");
  end

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_TIME - 1);

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [WAY_W-1:0]   activeWay_q, activeWay_d;
  logic [WAY_W-1:0]   nextWay_q, nextWay_d;
  logic [CNT_W-1:0]   counter_q, counter_d;

  logic [NUM_WAYS-1:0] otherReq;
  logic                ownReq;
  logic                greenExit;
  logic [WAY_W-1:0]    rrWay;
  logic [WAY_W-1:0]    prioWay;

  assign otherReq  = req & ~(NUM_WAYS'(1) << activeWay_q);
  assign ownReq    = req[activeWay_q];
  assign greenExit = (otherReq != '0) && (counter_q >= MIN_LAST) &&
                     (!ownReq || (counter_q >= MAX_LAST));

  // Descending scans so the candidate nearest the start of the search wins.
  always_comb begin
    rrWay   = activeWay_q;
    prioWay = '0;
    for (int k = NUM_WAYS - 1; k >= 1; k--) begin
      if (otherReq[(int'(activeWay_q) + k) % NUM_WAYS]) begin
        rrWay = WAY_W'((int'(activeWay_q) + k) % NUM_WAYS);
      end
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (otherReq[i]) begin
        prioWay = WAY_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= GREEN;
      activeWay_q <= '0;
      nextWay_q   <= '0;
      counter_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      activeWay_q <= activeWay_d;
      nextWay_q   <= nextWay_d;
      counter_q   <= counter_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    activeWay_d = activeWay_q;
    nextWay_d   = nextWay_q;
    counter_d   = counter_q;
    unique case (phase_q)
      GREEN: begin
        if (greenExit) begin
          phase_d   = YELLOW;
          counter_d = '0;
          nextWay_d = prio_mode ? prioWay : rrWay;
        end else if (counter_q < MAX_LAST) begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      YELLOW: begin
        if (counter_q == YELLOW_LAST) begin
          phase_d   = ALL_RED;
          counter_d = '0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      ALL_RED: begin
        if (counter_q == ALLRED_LAST) begin
          phase_d     = GREEN;
          activeWay_d = nextWay_q;
          counter_d   = '0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d   = GREEN;
        counter_d = '0;
      end
    endcase
  end

  assign green       = (phase_q == GREEN)  ? (NUM_WAYS'(1) << activeWay_q) : '0;
  assign yellow      = (phase_q == YELLOW) ? (NUM_WAYS'(1) << activeWay_q) : '0;
  assign active_way  = activeWay_q;
  assign phase       = phase_q;
  assign counter_out = counter_q;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Bench for traffic_ctrl_nway: directed scenarios with constant expectations,
// then randomized requests/resets checked against a rule-level reference model.
module tb_traffic_ctrl_nway;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int MING = 2;
  localparam int MAXG = 8;
  localparam int YT   = 2;
  localparam int ART  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          prioMode = 1'b0;
  logic [N-1:0]  green;
  logic [N-1:0]  yellow;
  logic [1:0]    activeWay;
  logic [1:0]    phase;
  logic [CW-1:0] counterOut;

  int tests = 0;
  int fails = 0;

  int mPhase = 0;
  int mWay   = 0;
  int mCnt   = 0;
  int mNext  = 0;

  always #5 clk = ~clk;

  traffic_ctrl_nway #(
    .NUM_WAYS(N), .CNT_W(CW), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
    .YELLOW_TIME(YT), .ALL_RED_TIME(ART)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .prio_mode(prioMode),
    .green(green), .yellow(yellow), .active_way(activeWay),
    .phase(phase), .counter_out(counterOut)
  );

  function automatic int pickNext(int way, logic [N-1:0] waiting, logic prio);
    if (prio) begin
      for (int i = 0; i < N; i++) if (waiting[i]) return i;
    end else begin
      for (int d = 1; d < N; d++) if (waiting[(way + d) % N]) return (way + d) % N;
    end
    return way;
  endfunction

  // One clock of the reference: timers per phase, winner chosen at green exit.
  task automatic modelStep();
    logic [N-1:0] others;
    if (rst) begin
      mPhase = 0; mWay = 0; mCnt = 0; mNext = 0;
      return;
    end
    case (mPhase)
      0: begin
        others = req;
        others[mWay] = 1'b0;
        if (others != 0 && mCnt >= MING - 1 && (!req[mWay] || mCnt >= MAXG - 1)) begin
          mNext = pickNext(mWay, others, prioMode);
          mPhase = 1; mCnt = 0;
        end else if (mCnt < MAXG - 1) begin
          mCnt++;
        end
      end
      1: if (mCnt == YT - 1) begin mPhase = 2; mCnt = 0; end else mCnt++;
      default: if (mCnt == ART - 1) begin mPhase = 0; mWay = mNext; mCnt = 0; end else mCnt++;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyReset(input logic [N-1:0] r);
    rst = 1'b1;
    req = r;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    applyReset('0);
    tests++; if (green !== 4'b0001) begin fails++; $display("[TB] FAIL reset_green: got %b expected 0001", green); end
    tests++; if (yellow !== 4'b0000) begin fails++; $display("[TB] FAIL reset_yellow: got %b expected 0000", yellow); end
    tests++; if (phase !== 2'd0) begin fails++; $display("[TB] FAIL reset_phase: got %0d expected 0", phase); end
    tests++; if (activeWay !== 2'd0) begin fails++; $display("[TB] FAIL reset_way: got %0d expected 0", activeWay); end
    tests++; if (counterOut !== 8'd0) begin fails++; $display("[TB] FAIL reset_counter: got %0d expected 0", counterOut); end
  endtask

  task automatic test_idle();
    applyReset('0);
    for (int c = 0; c < 20; c++) begin
      tests++; if (green !== 4'b0001) begin fails++; $display("[TB] FAIL idle_green c%0d: got %b expected 0001", c, green); end
      tests++; if (counterOut !== 8'((c < 7) ? c : 7)) begin
        fails++; $display("[TB] FAIL idle_counter c%0d: got %0d expected %0d", c, counterOut, (c < 7) ? c : 7);
      end
      tick();
    end
  endtask

  task automatic test_single_request();
    logic [N-1:0] eg, ey;
    logic [1:0]   ep;
    applyReset(4'b0100);
    for (int c = 0; c < 6; c++) begin
      if (c < 2)       begin eg = 4'b0001; ey = 4'b0000; ep = 2'd0; end
      else if (c < 4)  begin eg = 4'b0000; ey = 4'b0001; ep = 2'd1; end
      else if (c == 4) begin eg = 4'b0000; ey = 4'b0000; ep = 2'd2; end
      else             begin eg = 4'b0100; ey = 4'b0000; ep = 2'd0; end
      tests++; if (green !== eg) begin fails++; $display("[TB] FAIL single_green c%0d: got %b expected %b", c, green, eg); end
      tests++; if (yellow !== ey) begin fails++; $display("[TB] FAIL single_yellow c%0d: got %b expected %b", c, yellow, ey); end
      tests++; if (phase !== ep) begin fails++; $display("[TB] FAIL single_phase c%0d: got %0d expected %0d", c, phase, ep); end
      if (c < 5) tick();
    end
    tests++; if (activeWay !== 2'd2) begin fails++; $display("[TB] FAIL single_way: got %0d expected 2", activeWay); end
    tests++; if (counterOut !== 8'd0) begin fails++; $display("[TB] FAIL single_counter: got %0d expected 0", counterOut); end
  endtask

  task automatic test_max_green();
    applyReset(4'b0011);
    for (int c = 0; c < 8; c++) begin
      tests++; if (green !== 4'b0001 || counterOut !== 8'(c)) begin
        fails++; $display("[TB] FAIL maxg_green c%0d: got %b/%0d expected 0001/%0d", c, green, counterOut, c);
      end
      tick();
    end
    for (int c = 8; c < 10; c++) begin
      tests++; if (yellow !== 4'b0001 || green !== 4'b0000) begin
        fails++; $display("[TB] FAIL maxg_yellow c%0d: got y=%b g=%b expected y=0001 g=0000", c, yellow, green);
      end
      tick();
    end
    tests++; if (phase !== 2'd2 || (green | yellow) !== 4'b0000) begin
      fails++; $display("[TB] FAIL maxg_allred: got phase %0d lamps %b expected 2/0000", phase, green | yellow);
    end
    tick();
    tests++; if (green !== 4'b0010 || activeWay !== 2'd1) begin
      fails++; $display("[TB] FAIL maxg_next: got %b way %0d expected 0010 way 1", green, activeWay);
    end
  endtask

  task automatic test_rr_vs_prio();
    for (int p = 0; p < 2; p++) begin
      applyReset(4'b0100);
      prioMode = p[0];
      repeat (5) tick();
      tests++; if (activeWay !== 2'd2) begin fails++; $display("[TB] FAIL sel_setup p%0d: got way %0d expected 2", p, activeWay); end
      req = 4'b1011;
      repeat (5) tick();
      tests++; if (activeWay !== ((p == 0) ? 2'd3 : 2'd0) || phase !== 2'd0) begin
        fails++; $display("[TB] FAIL sel_next p%0d: got way %0d phase %0d expected way %0d phase 0",
                          p, activeWay, phase, (p == 0) ? 3 : 0);
      end
    end
    prioMode = 1'b0;
  endtask

  task automatic test_request_drop();
    applyReset(4'b0100);
    repeat (2) tick();
    tests++; if (phase !== 2'd1) begin fails++; $display("[TB] FAIL drop_yellow: got phase %0d expected 1", phase); end
    req = 4'b0000;
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      tests++; if (green !== 4'b0100 || phase !== 2'd0) begin
        fails++; $display("[TB] FAIL drop_hold c%0d: got %b phase %0d expected 0100 phase 0", c, green, phase);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_yellow();
    applyReset(4'b0010);
    repeat (5) tick();
    req = 4'b0001;
    repeat (2) tick();
    tests++; if (yellow !== 4'b0010) begin fails++; $display("[TB] FAIL midrst_setup: got yellow %b expected 0010", yellow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (green !== 4'b0001 || yellow !== 4'b0000 || counterOut !== 8'd0 || phase !== 2'd0) begin
      fails++; $display("[TB] FAIL midrst: got g=%b y=%b cnt=%0d ph=%0d expected 0001/0000/0/0",
                        green, yellow, counterOut, phase);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eg, ey;
    applyReset('0);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      prioMode = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 59) == 0);
      tick();
      rst = 1'b0;
      eg = (mPhase == 0) ? (N'(1) << mWay) : '0;
      ey = (mPhase == 1) ? (N'(1) << mWay) : '0;
      tests++; if (green !== eg || yellow !== ey) begin
        fails++; $display("[TB] FAIL rand_lamps c%0d: got g=%b y=%b expected g=%b y=%b", c, green, yellow, eg, ey);
      end
      tests++; if (phase !== 2'(mPhase) || activeWay !== 2'(mWay) || counterOut !== 8'(mCnt)) begin
        fails++; $display("[TB] FAIL rand_state c%0d: got ph=%0d way=%0d cnt=%0d expected ph=%0d way=%0d cnt=%0d",
                          c, phase, activeWay, counterOut, mPhase, mWay, mCnt);
      end
      tests++; if ($countones(green | yellow) > 1 || (green & yellow) !== '0) begin
        fails++; $display("[TB] FAIL rand_onehot c%0d: got g=%b y=%b expected at most one lamp", c, green, yellow);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_request();
    test_max_green();
    test_rr_vs_prio();
    test_request_drop();
    test_reset_mid_yellow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
